// File: rtl/fifo_pkg.sv
// Constants shared by the synchronous MSB-flag FIFO and its drain stage.
package fifo_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int DEPTH      = 1 << ADDR_WIDTH;
   localparam int OCC_WIDTH  = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream of the drain stage.
// master: the drain stage; slave: the FIFO and consumer side.
import fifo_pkg::*;

interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_rd_data, m_ready,
      output fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_rd_data, m_ready,
      input  fifo_rd_en, m_valid, m_data
   );

endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry in-order buffer absorbing FIFO read latency and backpressure.
import fifo_pkg::*;

module skid_buf2 #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [OCC_WIDTH-1:0]  occ
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  head;
   logic                  tail;

   // Storage, pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain stage: FIFO pop interface to a bubble-free valid/ready stream.
import fifo_pkg::*;

module fifo_stream_reader #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   fifo_stream_reader_if.master bus,
   output logic [CNT_WIDTH-1:0] words_out
);

   logic                 inflight;
   logic                 pop;
   logic                 rd_en;
   logic [OCC_WIDTH-1:0] occ;
   logic [2:0]           demand;

   assign pop = bus.m_valid && bus.m_ready;

   // Pop only when the word it returns is guaranteed a buffer slot.
   // demand cannot underflow: pop implies occ >= 1.
   always_comb begin
      demand = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      rd_en  = !rst && en && !bus.fifo_empty && (demand < 3'd2);
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ != '0);

   // Remember last cycle's pop: its data is on fifo_rd_data this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= rd_en;
      end
   end

   // Count completed output transfers, wrapping naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         words_out <= '0;
      end else if (pop) begin
         words_out <= words_out + CNT_WIDTH'(1);
      end
   end

   skid_buf2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .push_data(bus.fifo_rd_data),
      .pop      (pop),
      .head_data(bus.m_data),
      .occ      (occ)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model.
module tb_fifo_stream_reader;
   import fifo_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        ready = 1'b0;
   logic [15:0] words_out;
   logic [3:0]  words_out4;

   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned fails = 0;
   int unsigned ovf_errs = 0;

   fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();
   fifo_stream_reader_if #(.DATA_WIDTH(8)) bus4 ();

   fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .bus(bus), .words_out(words_out)
   );

   // Narrow-counter copy sees identical inputs, so it follows the same pops.
   fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .bus(bus4), .words_out(words_out4)
   );

   always #5 clk = ~clk;

   // FIFO model: preloaded by the initial block, popped by dut.
   logic [7:0]  fmem [0:63];
   int unsigned fhead = 0;
   int unsigned ftail = 0;

   assign bus.fifo_empty    = (fhead == ftail);
   assign bus.m_ready       = ready;
   assign bus4.fifo_empty   = bus.fifo_empty;
   assign bus4.fifo_rd_data = bus.fifo_rd_data;
   assign bus4.m_ready      = ready;

   always @(posedge clk) begin
      if (rst) begin
         fhead            <= 0;
         bus.fifo_rd_data <= '0;
      end else if (bus.fifo_rd_en) begin
         bus.fifo_rd_data <= fmem[fhead[5:0]];
         fhead            <= fhead + 1;
      end
   end

   // Record pops and delivered words.
   logic [7:0]  got [0:63];
   int unsigned got_n = 0;
   int unsigned pops = 0;

   always @(posedge clk) begin
      if (rst) begin
         got_n <= 0;
         pops  <= 0;
      end else begin
         if (bus.fifo_rd_en) pops <= pops + 1;
         if (bus.m_valid && bus.m_ready) begin
            got[got_n[5:0]] <= bus.m_data;
            got_n           <= got_n + 1;
         end
      end
   end

   // A capture into a full, non-draining buffer would lose a word.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(dut.inflight && dut.u_buf.occ == 2'd2 && !dut.pop) && dut.u_buf.occ <= 2'd2)
         else begin
            ovf_errs++;
            $error("FAIL overflow: occ=%0d inflight=%0b pop=%0b", dut.u_buf.occ, dut.inflight, dut.pop);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reset, preload n words base.., release reset mid-cycle N.
   task automatic start(input int unsigned n, input logic [7:0] base, input logic rdy);
      @(negedge clk);
      rst = 1'b1; en = 1'b0; ready = 1'b0; ftail = 0;
      @(negedge clk);
      for (int i = 0; i < int'(n); i++) fmem[i] = 8'(base + 8'(i));
      ftail = n;
      chk("rden_low_in_rst", bus.fifo_rd_en, 0);
      @(negedge clk);
      rst = 1'b0; en = 1'b1; ready = rdy;
      #1;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_data", bus.m_data, 0);
      chk("rst_words", words_out, 0);
      chk("rst_words4", words_out4, 0);
      chk("rst_rden", bus.fifo_rd_en, 0);

      // Streaming: one word per cycle, first valid two cycles after first pop
      start(8, 8'h01, 1'b1);
      chk("lat_rden_N", bus.fifo_rd_en, 1);
      chk("lat_valid_N", bus.m_valid, 0);
      @(negedge clk);
      chk("lat_valid_N1", bus.m_valid, 0);
      chk("lat_rden_N1", bus.fifo_rd_en, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("stream_valid", bus.m_valid, 1);
         chk("stream_data", bus.m_data, 32'(1 + i));
      end
      @(negedge clk);
      chk("stream_end_valid", bus.m_valid, 0);
      chk("stream_words", words_out, 8);
      chk("stream_rden_off", bus.fifo_rd_en, 0);
      chk("stream_pops", pops, 8);

      // Backpressure: two pops while stalled, head held
      start(8, 8'h01, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            chk("bp_valid", bus.m_valid, 1);
            chk("bp_data", bus.m_data, 8'h01);
         end
      end
      chk("bp_pops", pops, 2);
      chk("bp_words0", words_out, 0);
      ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("bp_count", got_n, 8);
      for (int i = 0; i < 8; i++) chk("bp_order", got[i], 32'(1 + i));
      chk("bp_words", words_out, 8);

      // Alternating stall over 16 words
      start(16, 8'h10, 1'b0);
      repeat (48) begin
         @(negedge clk);
         ready = ~ready;
      end
      chk("alt_count", got_n, 16);
      for (int i = 0; i < 16; i++) chk("alt_order", got[i], 32'(8'h10 + i));
      chk("alt_words", words_out, 16);

      // Enable gating after the third pop
      start(8, 8'h01, 1'b1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      #1;
      chk("en_rden_off", bus.fifo_rd_en, 0);
      repeat (6) begin
         @(negedge clk);
         chk("en_rden_held", bus.fifo_rd_en, 0);
      end
      chk("en_pops", pops, 3);
      chk("en_count", got_n, 3);
      chk("en_words", words_out, 3);
      chk("en_valid", bus.m_valid, 0);
      for (int i = 0; i < 3; i++) chk("en_order", got[i], 32'(1 + i));
      en = 1'b1;
      repeat (10) @(negedge clk);
      chk("en_resume_count", got_n, 8);
      for (int i = 0; i < 8; i++) chk("en_resume_order", got[i], 32'(1 + i));
      chk("en_resume_words", words_out, 8);

      // Reset mid-stream with a word in flight
      start(8, 8'h01, 1'b1);
      repeat (4) @(negedge clk);
      chk("mrst_pre_words", words_out, 2);
      chk("mrst_pre_data", bus.m_data, 8'h03);
      chk("mrst_pre_inflight", dut.inflight, 1);
      rst = 1'b1; ready = 1'b0; ftail = 0;
      @(negedge clk);
      chk("mrst_valid", bus.m_valid, 0);
      chk("mrst_words", words_out, 0);
      chk("mrst_data", bus.m_data, 0);
      chk("mrst_rden", bus.fifo_rd_en, 0);
      rst = 1'b0; en = 1'b1; ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("mrst_no_stale", bus.m_valid, 0);
      end
      chk("mrst_got", got_n, 0);

      // Counter wrap on the 4-bit instance
      start(20, 8'h40, 1'b1);
      repeat (26) @(negedge clk);
      chk("wrap_count", got_n, 20);
      chk("wrap_last", got[19], 8'h53);
      chk("wrap_words16", words_out, 20);
      chk("wrap_words4", words_out4, 4);
      chk("wrap_valid4", bus4.m_valid, 0);
      chk("wrap_rden4", bus4.fifo_rd_en, 0);

      chk("no_overflow", ovf_errs, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
